// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM duty button conditioner.
// Channel state encoding and counter sizing.
package pwm_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } chan_state_t;

   // Wide enough for the largest count plus one spare bit.
   function automatic int cnt_width(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) m = 2;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM,
// auto-repeat timer, registered pulse and held flags.
module btn_debounce_channel
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
   parameter int unsigned REPEAT_DELAY_CYCLES = 50000000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 20000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_raw_i,
   output logic pulse_o,
   output logic held_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES,
                                 REPEAT_DELAY_CYCLES,
                                 REPEAT_RATE_CYCLES);

   // Repeat intervals below 2 would merge adjacent pulses,
   // so they are stretched to keep a low cycle between them.
   localparam int unsigned DLY_EFF =
      (REPEAT_DELAY_CYCLES == 0) ? 0 :
      (REPEAT_DELAY_CYCLES < 2)  ? 2 : REPEAT_DELAY_CYCLES;
   localparam int unsigned RATE_EFF =
      (REPEAT_RATE_CYCLES < 2) ? 2 : REPEAT_RATE_CYCLES;
   localparam bit REPEAT_EN = (DLY_EFF != 0);

   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] DEB_LAST =
      (DEBOUNCE_CYCLES == 0) ? '0 : CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST =
      (DLY_EFF == 0) ? '0 : CW'(DLY_EFF - 1);
   localparam logic [CW-1:0] RATE_LAST = CW'(RATE_EFF - 1);

   logic          s1_q;
   logic          s2_q;
   chan_state_t   state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] rc_q;
   logic          first_q;
   logic          pulse_q;
   logic          held_q;
   logic [CW-1:0] rc_last;

   assign rc_last = first_q ? DLY_LAST : RATE_LAST;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_raw_i;
         s2_q <= s1_q;
      end
   end

   // Debounce FSM with auto-repeat; pulse and held are registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rc_q    <= '0;
         first_q <= 1'b0;
         pulse_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         held_q  <= (state_q == HELD) ||
                    (state_q == RELEASE_WAIT);
         unique case (state_q)
            IDLE: begin
               if (s2_q) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s2_q) begin
                  state_q <= IDLE;
               end else if (cnt_q == DEB_LAST) begin
                  state_q <= HELD;
                  pulse_q <= 1'b1;
                  rc_q    <= '0;
                  first_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            HELD: begin
               if (!s2_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end else if (REPEAT_EN) begin
                  if (rc_q == rc_last) begin
                     pulse_q <= 1'b1;
                     rc_q    <= '0;
                     first_q <= 1'b0;
                  end else begin
                     rc_q <= rc_q + ONE;
                  end
               end
            end
            RELEASE_WAIT: begin
               // A bounce back to pressed resumes the hold silently.
               if (s2_q) begin
                  state_q <= HELD;
                  rc_q    <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pulse_o = pulse_q;
   assign held_o  = held_q;

endmodule

// File: rtl/pwm_duty_button_conditioner.sv
// Conditions the duty up/down buttons into exclusive
// single-cycle pulses for the PWM generator.
module pwm_duty_button_conditioner
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
   parameter int unsigned REPEAT_DELAY_CYCLES = 50000000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 20000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_inc_raw,
   input  logic btn_dec_raw,
   output logic increase_duty,
   output logic decrease_duty,
   output logic inc_held,
   output logic dec_held
);

   logic inc_pulse;
   logic dec_pulse;
   logic inc_held_int;
   logic dec_held_int;
   logic inc_duty_q;
   logic dec_duty_q;
   logic inc_duty_d;
   logic dec_duty_d;

   btn_debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
   ) u_inc (
      .clk_i     (clk),
      .rst_i     (rst),
      .btn_raw_i (btn_inc_raw),
      .pulse_o   (inc_pulse),
      .held_o    (inc_held_int)
   );

   btn_debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
   ) u_dec (
      .clk_i     (clk),
      .rst_i     (rst),
      .btn_raw_i (btn_dec_raw),
      .pulse_o   (dec_pulse),
      .held_o    (dec_held_int)
   );

   // A pulse survives only if the other channel is quiet and not held.
   assign inc_duty_d = inc_pulse & ~dec_pulse & ~dec_held_int;
   assign dec_duty_d = dec_pulse & ~inc_pulse & ~inc_held_int;

   // Register the arbitrated pulses at the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         inc_duty_q <= 1'b0;
         dec_duty_q <= 1'b0;
      end else begin
         inc_duty_q <= inc_duty_d;
         dec_duty_q <= dec_duty_d;
      end
   end

   assign increase_duty = inc_duty_q;
   assign decrease_duty = dec_duty_q;
   assign inc_held      = inc_held_int;
   assign dec_held      = dec_held_int;

endmodule

// File: tb/tb_pwm_duty_button_conditioner.sv
// Scoreboard bench: random and directed button activity compared
// against a run-length reference model of the conditioner.
module tb_pwm_duty_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_inc_raw = 1'b0;
   logic btn_dec_raw = 1'b0;
   logic increase_duty;
   logic decrease_duty;
   logic inc_held;
   logic dec_held;

   always #5 clk = ~clk;

   pwm_duty_button_conditioner #(
      .DEBOUNCE_CYCLES     (D),
      .REPEAT_DELAY_CYCLES (RD),
      .REPEAT_RATE_CYCLES  (RR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_inc_raw   (btn_inc_raw),
      .btn_dec_raw   (btn_dec_raw),
      .increase_duty (increase_duty),
      .decrease_duty (decrease_duty),
      .inc_held      (inc_held),
      .dec_held      (dec_held)
   );

   // Model of one button: accepted level, length of the current
   // disagreeing run, and time since the last accepted pulse.
   typedef struct {
      bit acc;
      int run;
      int t;
      bit first;
      bit pulse;
   } chm_t;

   typedef struct {
      bit inc;
      bit dec;
      bit ih;
      bit dh;
   } exp_t;

   exp_t sbq[$];
   chm_t mi, md;
   bit   s1i, s2i, s1d, s2d;
   bit   hiq, hdq;
   int   errors = 0;
   int   checks = 0;

   function automatic chm_t ch_step(input chm_t c, input bit s);
      c.pulse = 1'b0;
      if (s != c.acc) begin
         c.run++;
         // D+1 consecutive agreeing samples flip the accepted level.
         if (c.run == D + 1) begin
            c.acc = s;
            c.run = 0;
            if (s) begin
               c.pulse = 1'b1;
               c.t = 0;
               c.first = 1'b1;
            end
         end
      end else begin
         if (c.acc) begin
            if (c.run > 0) begin
               c.t = 0;
            end else if (RD != 0) begin
               c.t++;
               if (c.t == (c.first ? RD : RR)) begin
                  c.pulse = 1'b1;
                  c.t = 0;
                  c.first = 1'b0;
               end
            end
         end
         c.run = 0;
      end
      return c;
   endfunction

   task automatic model_edge(input bit r, input bit ri, input bit rdv);
      exp_t e;
      if (r) begin
         mi = '{default: 0};
         md = '{default: 0};
         s1i = 0; s2i = 0; s1d = 0; s2d = 0;
         hiq = 0; hdq = 0;
         e = '{default: 0};
      end else begin
         e.inc = mi.pulse & ~md.pulse & ~hdq;
         e.dec = md.pulse & ~mi.pulse & ~hiq;
         e.ih  = mi.acc;
         e.dh  = md.acc;
         hiq = e.ih;
         hdq = e.dh;
         mi = ch_step(mi, s2i);
         md = ch_step(md, s2d);
         s2i = s1i; s1i = ri;
         s2d = s1d; s1d = rdv;
      end
      sbq.push_back(e);
   endtask

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic step(input bit r, input bit i, input bit d);
      rst = r;
      btn_inc_raw = i;
      btn_dec_raw = d;
      @(posedge clk);
      model_edge(r, i, d);
      @(negedge clk);
   endtask

   // Monitor: compare each registered output set against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if ({increase_duty, decrease_duty, inc_held, dec_held} !==
             {e.inc, e.dec, e.ih, e.dh}) begin
            errors++;
            $display("FAIL outputs t=%0t got inc=%b dec=%b ih=%b dh=%b exp inc=%b dec=%b ih=%b dh=%b",
                     $time, increase_duty, decrease_duty, inc_held,
                     dec_held, e.inc, e.dec, e.ih, e.dh);
         end
         if (increase_duty && decrease_duty) begin
            checks++;
            errors++;
            $display("FAIL exclusive: got both high expected at most one");
         end
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0);
   endtask

   task automatic bouncy(input bit on_i, input bit on_d, input int len);
      int nb;
      nb = $urandom_range(0, 6);
      for (int k = 0; k < nb; k++) begin
         bit v;
         v = $urandom_range(0, 1);
         step(0, on_i & v, on_d & v);
      end
      for (int k = 0; k < len; k++) step(0, on_i, on_d);
      nb = $urandom_range(0, 6);
      for (int k = 0; k < nb; k++) begin
         bit v;
         v = $urandom_range(0, 1);
         step(0, on_i & v, on_d & v);
      end
   endtask

   initial begin
      int first_p, np, rise, fall, anyo;
      int ev[$];
      int exp3[7] = '{7, 17, 22, 27, 32, 37, 42};

      step(1, 0, 0);
      step(1, 0, 0);
      chk("reset inc", int'(increase_duty), 0);
      chk("reset held", int'(inc_held), 0);
      idle(10);

      // Clean inc press held 12 cycles.
      first_p = -1; np = 0; rise = -1; fall = -1; anyo = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, i < 12, 0);
         if (increase_duty) begin
            np++;
            if (first_p < 0) first_p = i;
         end
         if (inc_held && rise < 0) rise = i;
         if (!inc_held && rise >= 0 && fall < 0) fall = i;
         if (decrease_duty) anyo = 1;
      end
      chk("t1 pulse count", np, 1);
      chk("t1 pulse edge", first_p, 7);
      chk("t1 held rise", rise, 7);
      chk("t1 held fall", fall, 19);
      chk("t1 dec quiet", anyo, 0);
      idle(10);

      // Toggling then stable press.
      first_p = -1;
      for (int i = 0; i < 4; i++) step(0, (i % 2) == 0, 0);
      for (int i = 0; i < 14; i++) begin
         step(0, 1, 0);
         if (increase_duty && first_p < 0) first_p = i;
      end
      chk("t2 pulse edge", first_p, 7);
      idle(20);

      // Dec held 40 cycles with auto-repeat.
      ev.delete();
      for (int i = 0; i < 60; i++) begin
         step(0, 0, i < 40);
         if (decrease_duty) ev.push_back(i);
      end
      chk("t3 pulse count", ev.size(), 7);
      for (int k = 0; k < 7; k++)
         if (k < ev.size()) chk("t3 pulse edge", ev[k], exp3[k]);
      idle(10);

      // Both buttons together.
      anyo = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 1, 1);
         if (increase_duty || decrease_duty) anyo = 1;
         if (i == 6) chk("t4 held early", int'({inc_held, dec_held}), 0);
         if (i == 7) chk("t4 held both", int'({inc_held, dec_held}), 3);
      end
      chk("t4 no pulses", anyo, 0);
      idle(15);

      // Inc held, dec pressed for 8 cycles.
      for (int i = 0; i < 20; i++) step(0, 1, 0);
      anyo = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1);
         if (decrease_duty) anyo = 1;
      end
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 0);
         if (decrease_duty) anyo = 1;
      end
      chk("t5 dec suppressed", anyo, 0);
      idle(15);

      // Reset mid-press.
      first_p = -1;
      for (int i = 0; i < 20; i++) begin
         step(i == 5, 1, 0);
         if (i == 5) chk("t6 reset out", int'(increase_duty), 0);
         if (i > 5 && increase_duty && first_p < 0) first_p = i;
      end
      chk("t6 pulse edge", first_p, 13);
      idle(15);

      // Random segments checked only by the scoreboard.
      for (int s = 0; s < 60; s++) begin
         int kind;
         kind = $urandom_range(0, 5);
         case (kind)
            0: idle($urandom_range(1, 12));
            1: bouncy(1, 0, $urandom_range(3, 40));
            2: bouncy(0, 1, $urandom_range(3, 40));
            3: for (int k = 0; k < 25; k++)
                  step(0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) == 0);
            4: step(1, $urandom_range(0, 1), $urandom_range(0, 1));
            default: begin
               bouncy(1, 0, $urandom_range(12, 30));
               bouncy(1, 1, $urandom_range(1, 10));
            end
         endcase
      end
      idle(20);

      @(posedge clk);
      @(negedge clk);
      chk("scoreboard drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
